boundary_update_ctrl: RTL and testbench

//   Sequences the draw_start/draw_end endpoints consumed by the boundary rotation datapath.

---
 rtl/boundary_update_ctrl.sv | 177 +++++++++++++++++
 tb/tb_boundary_update_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/boundary_update_ctrl.sv
// rtl/boundary_update_ctrl.sv - per-frame slewing of draw endpoints toward a handshaked target
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   VGA_X, VGA_Y                current raster position (vblank entry = (0, P_SCREEN_H))
//   freeze                      suppresses per-frame stepping; targets are still accepted
//   tgt_valid / tgt_ready       target endpoint handshake
//   tgt_start_x/y, tgt_end_x/y  offered target endpoints
//   draw_start_x/y, draw_end_x/y live endpoints to the rotation datapath
//   params_stable               low while the downstream theta pipeline refills
//   at_target                   live endpoints equal the target registers

module boundary_update_ctrl #(
  parameter int P_SCREEN_W = 640,
  parameter int P_SCREEN_H = 480,
  parameter int P_MAX_STEP = 4,
  parameter int P_SETTLE   = 2,
  parameter int P_INIT_SX  = 300,
  parameter int P_INIT_SY  = 200,
  parameter int P_INIT_EX  = 340,
  parameter int P_INIT_EY  = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] VGA_X,
  input  logic [10:0] VGA_Y,
  input  logic        freeze,
  input  logic        tgt_valid,
  output logic        tgt_ready,
  input  logic [10:0] tgt_start_x,
  input  logic [10:0] tgt_start_y,
  input  logic [10:0] tgt_end_x,
  input  logic [10:0] tgt_end_y,
  output logic [10:0] draw_start_x,
  output logic [10:0] draw_start_y,
  output logic [10:0] draw_end_x,
  output logic [10:0] draw_end_y,
  output logic        params_stable,
  output logic        at_target
);

  localparam logic [10:0]        X_MAX    = 11'(P_SCREEN_W - 1);
  localparam logic [10:0]        Y_MAX    = 11'(P_SCREEN_H - 1);
  localparam logic [10:0]        VB_ROW   = 11'(P_SCREEN_H);
  localparam logic [10:0]        STEP_U   = 11'(P_MAX_STEP);
  localparam logic signed [11:0] STEP_POS = 12'(P_MAX_STEP);
  localparam logic signed [11:0] STEP_NEG = -STEP_POS;
  localparam int                 CW       = (P_SETTLE > 1) ? $clog2(P_SETTLE + 1) : 1;
  localparam logic [CW-1:0]      SETTLE_LAST = CW'(P_SETTLE - 1);
  localparam logic [10:0]        INIT_SX  = 11'(P_INIT_SX);
  localparam logic [10:0]        INIT_SY  = 11'(P_INIT_SY);
  localparam logic [10:0]        INIT_EX  = 11'(P_INIT_EX);
  localparam logic [10:0]        INIT_EY  = 11'(P_INIT_EY);

  typedef enum logic [1:0] {S_RUN, S_STEP, S_SETTLE} state_t;

  state_t        state, state_nxt;
  logic          vblank_pulse;
  logic [CW-1:0] settle_cnt;

  logic [10:0] tgt_sx, tgt_sy, tgt_ex, tgt_ey;
  logic [10:0] snap_sx, snap_sy, snap_ex, snap_ey;
  logic [10:0] c_sx, c_sy, c_ex, c_ey;
  logic [10:0] tgt_sx_n, tgt_sy_n, tgt_ex_n, tgt_ey_n;
  logic [10:0] live_sx_n, live_sy_n, live_ex_n, live_ey_n;
  logic        xfer, degenerate, tgt_we, go_step;

  function automatic logic [10:0] clamp(input logic [10:0] v, input logic [10:0] hi);
    clamp = (v > hi) ? hi : v;
  endfunction

  // Move c toward t by at most P_MAX_STEP; when within range, land exactly on t.
  function automatic logic [10:0] slew(input logic [10:0] c, input logic [10:0] t);
    logic signed [11:0] d;
    d = $signed({1'b0, t}) - $signed({1'b0, c});
    if (d > STEP_POS)      slew = c + STEP_U;
    else if (d < STEP_NEG) slew = c - STEP_U;
    else                   slew = t;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    tgt_ready     = 1'b1;
    params_stable = 1'b1;
    go_step       = 1'b0;
    case (state)
      S_RUN: begin
        if (vblank_pulse && !freeze && !at_target) begin
          state_nxt = S_STEP;
          go_step   = 1'b1;
        end
      end
      S_STEP: begin
        tgt_ready = 1'b0;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        params_stable = 1'b0;
        if (settle_cnt == SETTLE_LAST) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    c_sx       = clamp(tgt_start_x, X_MAX);
    c_sy       = clamp(tgt_start_y, Y_MAX);
    c_ex       = clamp(tgt_end_x, X_MAX);
    c_ey       = clamp(tgt_end_y, Y_MAX);
    xfer       = tgt_valid && tgt_ready;
    degenerate = (c_sx == c_ex) && (c_sy == c_ey);
    tgt_we     = xfer && !degenerate;

    tgt_sx_n = tgt_we ? c_sx : tgt_sx;
    tgt_sy_n = tgt_we ? c_sy : tgt_sy;
    tgt_ex_n = tgt_we ? c_ex : tgt_ex;
    tgt_ey_n = tgt_we ? c_ey : tgt_ey;

    live_sx_n = draw_start_x;
    live_sy_n = draw_start_y;
    live_ex_n = draw_end_x;
    live_ey_n = draw_end_y;
    if (state == S_STEP) begin
      live_sx_n = slew(draw_start_x, snap_sx);
      live_sy_n = slew(draw_start_y, snap_sy);
      live_ex_n = slew(draw_end_x, snap_ex);
      live_ey_n = slew(draw_end_y, snap_ey);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_pulse <= 1'b0;
      settle_cnt   <= '0;
      tgt_sx       <= INIT_SX;
      tgt_sy       <= INIT_SY;
      tgt_ex       <= INIT_EX;
      tgt_ey       <= INIT_EY;
      snap_sx      <= INIT_SX;
      snap_sy      <= INIT_SY;
      snap_ex      <= INIT_EX;
      snap_ey      <= INIT_EY;
      draw_start_x <= INIT_SX;
      draw_start_y <= INIT_SY;
      draw_end_x   <= INIT_EX;
      draw_end_y   <= INIT_EY;
      at_target    <= 1'b1;
    end else begin
      vblank_pulse <= (VGA_X == 11'd0) && (VGA_Y == VB_ROW);
      settle_cnt   <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
      // Snapshot the target at the decision point so a target accepted in the
      // same cycle only affects the following frame.
      if (go_step) begin
        snap_sx <= tgt_sx;
        snap_sy <= tgt_sy;
        snap_ex <= tgt_ex;
        snap_ey <= tgt_ey;
      end
      tgt_sx       <= tgt_sx_n;
      tgt_sy       <= tgt_sy_n;
      tgt_ex       <= tgt_ex_n;
      tgt_ey       <= tgt_ey_n;
      draw_start_x <= live_sx_n;
      draw_start_y <= live_sy_n;
      draw_end_x   <= live_ex_n;
      draw_end_y   <= live_ey_n;
      at_target    <= ({live_sx_n, live_sy_n, live_ex_n, live_ey_n} ==
                       {tgt_sx_n, tgt_sy_n, tgt_ex_n, tgt_ey_n});
    end
  end

endmodule

// File: tb/tb_boundary_update_ctrl.sv
// tb/tb_boundary_update_ctrl.sv - self-checking bench for boundary_update_ctrl

module tb_boundary_update_ctrl;

  localparam int MAXSTEP = 4;
  localparam int XM = 639;
  localparam int YM = 479;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] VGA_X, VGA_Y;
  logic        freeze, tgt_valid, tgt_ready;
  logic [10:0] tgt_start_x, tgt_start_y, tgt_end_x, tgt_end_y;
  logic [10:0] draw_start_x, draw_start_y, draw_end_x, draw_end_y;
  logic        params_stable, at_target;

  boundary_update_ctrl dut (
    .clk(clk), .reset(reset), .VGA_X(VGA_X), .VGA_Y(VGA_Y), .freeze(freeze),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .tgt_start_x(tgt_start_x), .tgt_start_y(tgt_start_y),
    .tgt_end_x(tgt_end_x), .tgt_end_y(tgt_end_y),
    .draw_start_x(draw_start_x), .draw_start_y(draw_start_y),
    .draw_end_x(draw_end_x), .draw_end_y(draw_end_y),
    .params_stable(params_stable), .at_target(at_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit offer;
    int sx, sy, ex, ey;
    int frames;
    bit frz;
    int idle;
    int esx, esy, eex, eey;
    bit eat;
  } vec_t;

  typedef struct {
    logic [43:0] draws;
    bit          at;
    int          low;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   m_live[4];
  int   m_tgt[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [43:0] dut_draws();
    return {draw_start_x, draw_start_y, draw_end_x, draw_end_y};
  endfunction

  function automatic logic [43:0] model_draws();
    return {11'(m_live[0]), 11'(m_live[1]), 11'(m_live[2]), 11'(m_live[3])};
  endfunction

  function automatic int m_slew(int c, int t);
    if (t > c) return (t - c > MAXSTEP) ? c + MAXSTEP : t;
    if (c > t) return (c - t > MAXSTEP) ? c - MAXSTEP : t;
    return c;
  endfunction

  function automatic int m_clamp(int v, int hi);
    return (v > hi) ? hi : v;
  endfunction

  function automatic bit m_at();
    for (int i = 0; i < 4; i++) if (m_live[i] != m_tgt[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_live = '{300, 200, 340, 200};
    m_tgt  = '{300, 200, 340, 200};
  endtask

  task automatic model_offer(input int sx, input int sy, input int ex, input int ey);
    int c[4];
    c[0] = m_clamp(sx, XM);
    c[1] = m_clamp(sy, YM);
    c[2] = m_clamp(ex, XM);
    c[3] = m_clamp(ey, YM);
    if (!(c[0] == c[2] && c[1] == c[3])) m_tgt = c;
  endtask

  task automatic drive_tgt(input int sx, input int sy, input int ex, input int ey);
    tgt_start_x = 11'(sx);
    tgt_start_y = 11'(sy);
    tgt_end_x   = 11'(ex);
    tgt_end_y   = 11'(ey);
  endtask

  // Handshake during active video; ready is waited on with a cycle budget.
  task automatic offer(input int sx, input int sy, input int ex, input int ey);
    bit seen = 1'b0;
    drive_tgt(sx, sy, ex, ey);
    tgt_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (tgt_ready) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("offer_ready", seen, 1'b1);
    tick();
    tgt_valid = 1'b0;
    if (seen) model_offer(sx, sy, ex, ey);
    check("offer_at_target", at_target, m_at());
  endtask

  // One vblank; optionally offer a target in the same cycle as vblank_pulse.
  task automatic frame(input bit with_offer, input int sx, input int sy, input int ex, input int ey);
    bit   do_step;
    int   low;
    int   snap[4];
    exp_t e;
    exp_t g;
    do_step = !freeze && !m_at();
    VGA_X = 11'd0;
    VGA_Y = 11'd480;
    tick();
    VGA_X = 11'd1;
    if (with_offer) begin
      drive_tgt(sx, sy, ex, ey);
      tgt_valid = 1'b1;
      check("pulse_cycle_ready", tgt_ready, 1'b1);
    end
    snap = m_tgt;
    if (do_step) for (int i = 0; i < 4; i++) m_live[i] = m_slew(m_live[i], snap[i]);
    if (with_offer) model_offer(sx, sy, ex, ey);
    e.draws = model_draws();
    e.at    = m_at();
    e.low   = do_step ? 2 : 0;
    sb.push_back(e);
    tick();
    tgt_valid = 1'b0;
    VGA_Y = 11'd100;
    low = 0;
    for (int k = 0; k < 8; k++) begin
      if (!params_stable) low++;
      tick();
    end
    if (sb.size() == 0) begin
      check("sb_underflow", 1'b1, 1'b0);
    end else begin
      g = sb.pop_front();
      check("frame_draws", dut_draws(), g.draws);
      check("frame_at_target", at_target, g.at);
      check("frame_stable_low_cycles", low, g.low);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 300, 200, 350, 210, 1, 1'b0, 0,  300, 200, 344, 204, 1'b0};
    vecs[1] = '{1'b0, 0, 0, 0, 0,         1, 1'b0, 0,  300, 200, 348, 208, 1'b0};
    vecs[2] = '{1'b0, 0, 0, 0, 0,         1, 1'b0, 0,  300, 200, 350, 210, 1'b1};
    vecs[3] = '{1'b0, 0, 0, 0, 0,         1, 1'b0, 0,  300, 200, 350, 210, 1'b1};
    vecs[4] = '{1'b1, 700, 200, 350, 210, 0, 1'b0, 20, 300, 200, 350, 210, 1'b0};
    vecs[5] = '{1'b0, 0, 0, 0, 0,         2, 1'b0, 0,  308, 200, 350, 210, 1'b0};
    vecs[6] = '{1'b0, 0, 0, 0, 0,         2, 1'b1, 0,  308, 200, 350, 210, 1'b0};
    vecs[7] = '{1'b0, 0, 0, 0, 0,         1, 1'b0, 0,  312, 200, 350, 210, 1'b0};
    vecs[8] = '{1'b1, 320, 240, 320, 240, 1, 1'b0, 0,  316, 200, 350, 210, 1'b0};

    reset = 1'b1;
    VGA_X = 11'd0;
    VGA_Y = 11'd100;
    freeze = 1'b0;
    tgt_valid = 1'b0;
    drive_tgt(0, 0, 0, 0);
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("reset_draws", dut_draws(), {11'd300, 11'd200, 11'd340, 11'd200});
    check("reset_params_stable", params_stable, 1'b1);
    check("reset_at_target", at_target, 1'b1);
    check("reset_tgt_ready", tgt_ready, 1'b1);

    foreach (vecs[r]) begin
      bit bad;
      freeze = vecs[r].frz;
      if (vecs[r].offer) offer(vecs[r].sx, vecs[r].sy, vecs[r].ex, vecs[r].ey);
      for (int f = 0; f < vecs[r].frames; f++) frame(1'b0, 0, 0, 0, 0);
      bad = 1'b0;
      for (int k = 0; k < vecs[r].idle; k++) begin
        VGA_X = 11'(k * 7);
        VGA_Y = 11'(k * 20);
        tick();
        if (dut_draws() !== model_draws()) bad = 1'b1;
      end
      if (vecs[r].idle > 0) check("active_video_hold", bad, 1'b0);
      VGA_Y = 11'd100;
      check($sformatf("vec%0d_draws", r), dut_draws(),
            {11'(vecs[r].esx), 11'(vecs[r].esy), 11'(vecs[r].eex), 11'(vecs[r].eey)});
      check($sformatf("vec%0d_at_target", r), at_target, vecs[r].eat);
    end
    freeze = 1'b0;

    // Target accepted alongside vblank_pulse: this frame uses the old target (639).
    frame(1'b1, 300, 200, 350, 210);
    check("same_cycle_old_target", draw_start_x, 11'd320);
    frame(1'b0, 0, 0, 0, 0);
    check("next_frame_new_target", draw_start_x, 11'd316);

    // Reset landing in the middle of SETTLE.
    VGA_X = 11'd0;
    VGA_Y = 11'd480;
    tick();
    VGA_X = 11'd1;
    VGA_Y = 11'd100;
    tick();
    tick();
    check("settle_reached", params_stable, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("async_reset_draws", dut_draws(), model_draws());
    check("async_reset_stable", params_stable, 1'b1);
    check("async_reset_at_target", at_target, 1'b1);
    check("async_reset_ready", tgt_ready, 1'b1);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    check("post_reset_draws", dut_draws(), {11'd300, 11'd200, 11'd340, 11'd200});
    check("post_reset_stable", params_stable, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
